// File: rtl/icb_dma_mst_pkg.sv
// rtl/icb_dma_mst_pkg.sv - shared encodings and constants for the ICB DMA initiator
//
// Purpose: FSM state encoding, bus widths and the word stride shared by
//          icb_dma_mst and icb_ack_timer.
// Ports:   none (package).
package icb_dma_mst_pkg;

  localparam int unsigned ADR_W = 20;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned CNT_W = 16;

  // Byte distance between consecutive 32-bit words.
  localparam logic [ADR_W-1:0] WORD_STRIDE = 20'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/icb_dma_mst_ack_timer.sv
// rtl/icb_dma_mst_ack_timer.sv - request-without-ack timeout counter for ICB initiators
//
// Purpose: counts cycles a request is held without an acknowledge and flags
//          the cycle in which the request has been pending TIMEOUT cycles.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   req     in  request currently asserted
//   ack     in  acknowledge for the current request
//   expired out request has been high TIMEOUT cycles with no ack (this cycle included)
module icb_ack_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Any ack, or a gap in the request, restarts the count, so back-to-back
  // requests (read then write) each start from zero.
  always_comb begin
    cnt_d = 16'd0;
    if (req && !ack) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed waiting cycles, so LAST marks the TIMEOUT-th cycle.
  // An ack in that same cycle wins.
  assign expired = req && !ack && (cnt_q == LAST);

endmodule

// File: rtl/icb_dma_mst.sv
// rtl/icb_dma_mst.sv - ICB initiator that copies a block of 32-bit words
//
// Purpose: on start, reads len words from src_adr and writes them to dst_adr,
//          one read followed by one write per word, with a per-request timeout.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start                  launch pulse, ignored while busy
//   src_adr, dst_adr, len  transfer parameters, sampled on an accepted start
//   busy, done, err        status: in transfer, finish pulse, sticky timeout
//   icb_rd/radr/rdat/rack  read request channel
//   icb_wr/wadr/wdat/wack  write request channel
module icb_dma_mst
  import icb_dma_mst_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADR_W-1:0] src_adr,
  input  logic [ADR_W-1:0] dst_adr,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             icb_rd,
  output logic [ADR_W-1:0] icb_radr,
  input  logic [DAT_W-1:0] icb_rdat,
  input  logic             icb_rack,
  output logic             icb_wr,
  output logic [ADR_W-1:0] icb_wadr,
  output logic [DAT_W-1:0] icb_wdat,
  input  logic             icb_wack
);

  state_e           state_q, state_d;
  logic [ADR_W-1:0] sa_q, sa_d;
  logic [ADR_W-1:0] da_q, da_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DAT_W-1:0] data_q, data_d;
  logic             err_q, err_d;

  logic rd_req;
  logic wr_req;
  logic req_ack;
  logic expired;

  // Requests are decoded from state only; acks never feed them combinationally.
  assign rd_req  = (state_q == ST_RD);
  assign wr_req  = (state_q == ST_WR);
  assign req_ack = (rd_req && icb_rack) || (wr_req && icb_wack);

  icb_ack_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .rst    (rst),
    .req    (rd_req || wr_req),
    .ack    (req_ack),
    .expired(expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (len != '0) ? ST_RD : ST_FIN;
        end
      end
      ST_RD: begin
        if (icb_rack) begin
          state_d = ST_WR;
        end else if (expired) begin
          state_d = ST_FIN;
        end
      end
      ST_WR: begin
        if (icb_wack) begin
          // cnt_q is the pre-decrement count, so 1 means this was the last word.
          state_d = (cnt_q == CNT_W'(1)) ? ST_FIN : ST_RD;
        end else if (expired) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    sa_d   = sa_q;
    da_d   = da_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    err_d  = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sa_d  = src_adr;
          da_d  = dst_adr;
          cnt_d = len;
          err_d = 1'b0;
        end
      end
      ST_RD: begin
        if (icb_rack) begin
          data_d = icb_rdat;
        end else if (expired) begin
          err_d = 1'b1;
        end
      end
      ST_WR: begin
        if (icb_wack) begin
          // 20-bit addition wraps naturally at the top of the address space.
          sa_d  = sa_q + WORD_STRIDE;
          da_d  = da_q + WORD_STRIDE;
          cnt_d = cnt_q - CNT_W'(1);
        end else if (expired) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q   <= '0;
      da_q   <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      sa_q   <= sa_d;
      da_q   <= da_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  // Output decode: address/data buses are forced to zero when their request is low.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    icb_rd   = 1'b0;
    icb_wr   = 1'b0;
    icb_radr = '0;
    icb_wadr = '0;
    icb_wdat = '0;
    case (state_q)
      ST_RD: begin
        busy     = 1'b1;
        icb_rd   = 1'b1;
        icb_radr = sa_q;
      end
      ST_WR: begin
        busy     = 1'b1;
        icb_wr   = 1'b1;
        icb_wadr = da_q;
        icb_wdat = data_q;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  assign err = err_q;

endmodule
